// File: rtl/qrd_out_deskew.sv
// qrd_out_deskew: captures the diagonally skewed output beats of a 4x4 QRD
// array into an R buffer (and optionally a QH buffer), then drains the
// elements in row-major order over a valid/ready stream.
//
// Optional feature macro: QRD_DESKEW_QH_EN
//   defined   : QH is stored and drained after R (32 elements per frame)
//   undefined : only R is stored and drained (16 elements), out_sel is 0
//
// Handshake: an element transfers on any rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// element fields are held. out_valid never drops without a transfer, except
// on reset.
module qrd_out_deskew #(
    parameter int W = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] row_out_1_r,
    input  logic signed [W-1:0] row_out_1_i,
    input  logic signed [W-1:0] row_out_2_r,
    input  logic signed [W-1:0] row_out_2_i,
    input  logic signed [W-1:0] row_out_3_r,
    input  logic signed [W-1:0] row_out_3_i,
    input  logic signed [W-1:0] row_out_4_r,
    input  logic signed [W-1:0] row_out_4_i,
    output logic                cap_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_r,
    output logic signed [W-1:0] out_i,
    output logic                out_sel,
    output logic [1:0]          out_row,
    output logic [1:0]          out_col,
    output logic                frame_done,
    output logic                overflow,
    output logic [1:0]          dbg_state
);

`ifdef QRD_DESKEW_QH_EN
    localparam int N_ELEM = 32;
    localparam int IDX_W  = 5;
`else
    localparam int N_ELEM = 16;
    localparam int IDX_W  = 4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         t_q, t_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic               beat_acc;
    logic               xfer;
    logic               last_elem;

    logic signed [W-1:0] lane_re [4];
    logic signed [W-1:0] lane_im [4];
    logic signed [W-1:0] r_re_q [4][4];
    logic signed [W-1:0] r_re_d [4][4];
    logic signed [W-1:0] r_im_q [4][4];
    logic signed [W-1:0] r_im_d [4][4];
`ifdef QRD_DESKEW_QH_EN
    logic signed [W-1:0] qh_re_q [4][4];
    logic signed [W-1:0] qh_re_d [4][4];
    logic signed [W-1:0] qh_im_q [4][4];
    logic signed [W-1:0] qh_im_d [4][4];
`endif

    // Lane ports gathered into arrays so storage can be written by index.
    always_comb begin
        lane_re[0] = row_out_1_r;
        lane_im[0] = row_out_1_i;
        lane_re[1] = row_out_2_r;
        lane_im[1] = row_out_2_i;
        lane_re[2] = row_out_3_r;
        lane_im[2] = row_out_3_i;
        lane_re[3] = row_out_4_r;
        lane_im[3] = row_out_4_i;
    end

    assign cap_ready  = (state_q != ST_DRAIN);
    assign beat_acc   = in_valid && cap_ready;
    assign xfer       = out_valid_q && out_ready;
    assign last_elem  = (idx_q == IDX_W'(N_ELEM - 1));
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign dbg_state  = state_q;
    assign out_row    = idx_q[3:2];
    assign out_col    = idx_q[1:0];

    // Control next-state: beat counting, burst end, drain index and frame end.
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (in_valid & ~cap_ready);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CAPTURE;
                    t_d     = 4'd1;
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    if (t_q == 4'd10) begin
                        state_d     = ST_DRAIN;
                        t_d         = 4'd0;
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        t_d = t_q + 4'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    if (last_elem) begin
                        state_d      = ST_IDLE;
                        idx_d        = '0;
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            t_q          <= 4'd0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Deskew write: on beat t, lane k lands in column t-k (R) or t-k-4 (QH).
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                r_re_d[k][c] = r_re_q[k][c];
                r_im_d[k][c] = r_im_q[k][c];
                if (beat_acc && (t_q == 4'(k + c))) begin
                    r_re_d[k][c] = lane_re[k];
                    r_im_d[k][c] = lane_im[k];
                end
`ifdef QRD_DESKEW_QH_EN
                qh_re_d[k][c] = qh_re_q[k][c];
                qh_im_d[k][c] = qh_im_q[k][c];
                if (beat_acc && (t_q == 4'(k + c + 4))) begin
                    qh_re_d[k][c] = lane_re[k];
                    qh_im_d[k][c] = lane_im[k];
                end
`endif
            end
        end
    end

    // Sample buffers carry no reset; a reset frame is never drained.
    always_ff @(posedge clk) begin
        r_re_q <= r_re_d;
        r_im_q <= r_im_d;
`ifdef QRD_DESKEW_QH_EN
        qh_re_q <= qh_re_d;
        qh_im_q <= qh_im_d;
`endif
    end

    // Drain read mux; buffers are frozen in DRAIN, so fields hold while stalled.
    always_comb begin
        out_r   = r_re_q[idx_q[3:2]][idx_q[1:0]];
        out_i   = r_im_q[idx_q[3:2]][idx_q[1:0]];
        out_sel = 1'b0;
`ifdef QRD_DESKEW_QH_EN
        if (idx_q[4]) begin
            out_r   = qh_re_q[idx_q[3:2]][idx_q[1:0]];
            out_i   = qh_im_q[idx_q[3:2]][idx_q[1:0]];
            out_sel = 1'b1;
        end
`endif
    end

endmodule

// File: doc/qrd_out_deskew.md
QRD_OUT_DESKEW -- requirements
Module: qrd_out_deskew

Interface
REQ-001 SHALL have parameter W, default 14: width of each signed real/imag sample (10 fraction bits).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  high on each cycle the QRD array presents a skewed output beat.
REQ-005 SHALL have ports row_out_k_r / row_out_k_i (k=1..4)  input  W each  signed skewed lane k from the QRD array.
REQ-006 SHALL have port cap_ready  output  1  high when a new burst can be captured.
REQ-007 SHALL have port out_valid  output  1  drained element valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the element.
REQ-009 SHALL have ports out_r / out_i  output  W each  signed drained element.
REQ-010 SHALL have port out_sel  output  1  0 = R element, 1 = QH element.
REQ-011 SHALL have ports out_row / out_col  output  2 each  matrix indices of the drained element.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the last element of a frame transfers.
REQ-013 SHALL have port overflow  output  1  sticky flag: a beat arrived while cap_ready was low.

Function
REQ-014 SHALL implement states IDLE, CAPTURE and DRAIN; cap_ready SHALL be high in IDLE and CAPTURE and low in DRAIN.
REQ-015 SHALL count accepted beats t (in_valid && cap_ready); IDLE->CAPTURE on the first beat (t=0); cycles with in_valid low SHALL NOT advance t.
REQ-016 On beat t, for each lane k, e = t-(k-1); if 0<=e<4, SHALL store lane k into R[k-1][e]; if 4<=e<8, into QH[k-1][e-4]; otherwise lane k SHALL be ignored.
REQ-017 A burst SHALL be exactly 11 beats (t=0..10); CAPTURE->DRAIN on the cycle after beat t=10.
REQ-018 In DRAIN, SHALL emit R in row-major order (row 0 col 0 through row 3 col 3), then QH in row-major order, one element per transfer.
REQ-019 Transfer SHALL occur when out_valid && out_ready; out_r, out_i, out_sel, out_row and out_col SHALL stay stable while out_valid is high and out_ready is low.
REQ-020 out_valid SHALL rise on the first DRAIN cycle; with out_ready held high, SHALL deliver one element per cycle with no bubbles.
REQ-021 After the last transfer, SHALL pulse frame_done for one cycle, drop out_valid, and return to IDLE in that same cycle, so cap_ready is high on the next cycle.
REQ-022 A beat with in_valid high while in DRAIN SHALL be discarded without corrupting stored data, and SHALL set overflow.
REQ-023 overflow SHALL remain set until rst.
REQ-024 Sample values SHALL pass through unmodified: no rounding, saturation or sign change.

Reset
REQ-025 When rst is high at a clock edge, SHALL enter IDLE with t=0, drain index 0, out_valid=0, frame_done=0, overflow=0 and cap_ready=1.
REQ-026 A reset mid-CAPTURE or mid-DRAIN SHALL abandon the frame; the buffer contents after reset are undefined and SHALL NOT be emitted.

Configuration
REQ-027 Macro QRD_DESKEW_QH_EN: when defined, SHALL store and drain QH, giving 32 elements per frame.
REQ-028 Without QRD_DESKEW_QH_EN, SHALL not instantiate QH storage, SHALL ignore beats with e>=4, and SHALL drain only 16 R elements; out_sel SHALL be tied to 0.

Verification
REQ-029 Drive 11 consecutive beats, lane k value = 16*k+e (e in range), out_ready=1 -> 32 transfers: R[r][c]=16*(r+1)+c, then QH[r][c]=16*(r+1)+c+4, frame_done on the cycle after the last transfer.
REQ-030 Same burst with in_valid deasserted for 3 cycles after beat 5 -> output identical to REQ-029.
REQ-031 out_ready toggled 1,0,0,1 during DRAIN -> no lost or duplicated elements; outputs stable while stalled.
REQ-032 in_valid pulsed during DRAIN with lane values -1 -> overflow=1 and drained data unchanged.
REQ-033 rst asserted at DRAIN element 7 -> next cycle out_valid=0 and cap_ready=1; a following burst drains correctly from R[0][0].
REQ-034 Build without QRD_DESKEW_QH_EN, REQ-029 stimulus -> exactly 16 R transfers, out_sel=0 throughout, frame_done after R[3][3].
